// File: rtl/optical_pkg.sv
// Shared types and line-level constants for the optical receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package optical_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    PARITY   = 3'd3,
    STOP     = 3'd4,
    WAIT_LOW = 3'd5
  } rx_state_t;

  localparam logic START_BIT  = 1'b1;
  localparam logic STOP_BIT   = 1'b0;
  localparam logic IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/din_sync.sv
// Two-flop synchroniser bringing the asynchronous optical line into clk.
// Latency: 2 clk cycles from din to sync_out.
// Backpressure: none; free-running.
module din_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync_out
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  // Shift the raw line through the two metastability flops.
  always_comb begin
    sync_d = {sync_q[0], din};
  end

  // Synchroniser register, cleared to the idle (dark) level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= sync_d;
  end

  assign sync_out = sync_q[1];

endmodule

// File: rtl/optical_rx.sv
// Oversampling frame receiver: start, DATA_W bits LSB first, optional even parity, stop.
// Latency: vout/perr/ferr appear 3 clk cycles after the din stop-bit midpoint.
// Backpressure: none; results are single-cycle pulses, dout holds the last good payload.
module optical_rx
  import optical_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 4,
  parameter int PARITY_EN  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din,
  output logic [DATA_W-1:0] dout,
  output logic              vout,
  output logic              perr,
  output logic              ferr
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_W + 1);
  // The counter is cleared on the cycle after the edge is seen, so the
  // sample point OVERSAMPLE/2 after bit start lands on count OVERSAMPLE/2-1.
  localparam logic [CW-1:0] CYC_MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  logic              line;
  rx_state_t         state_q,     state_d;
  logic [CW-1:0]     cyc_q,       cyc_d;
  logic [BW-1:0]     bit_q,       bit_d;
  logic [DATA_W-1:0] shreg_q,     shreg_d;
  logic [DATA_W-1:0] dout_q,      dout_d;
  logic              par_err_q,   par_err_d;
  logic              line_prev_q, line_prev_d;
  logic [1:0]        settle_q,    settle_d;
  logic              armed_q,     armed_d;
  logic              vout_q,      vout_d;
  logic              perr_q,      perr_d;
  logic              ferr_q,      ferr_d;
  logic              mid;

  din_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .sync_out (line)
  );

  // Next-state, counters, shift register and result pulses.
  always_comb begin
    state_d     = state_q;
    cyc_d       = (cyc_q == CYC_LAST) ? '0 : cyc_q + 1'b1;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    dout_d      = dout_q;
    par_err_d   = par_err_q;
    line_prev_d = line;
    vout_d      = 1'b0;
    perr_d      = 1'b0;
    ferr_d      = 1'b0;
    mid         = (cyc_q == CYC_MID);

    // The synchroniser reads 0 for two cycles after reset regardless of din,
    // so only trust a low line once it has settled; until a real low is seen
    // a line that was already high cannot be mistaken for a start edge.
    settle_d = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
    armed_d  = armed_q | ((settle_q == 2'd2) && (line == IDLE_LEVEL));

    unique case (state_q)
      IDLE: begin
        cyc_d = '0;
        if (armed_q && (line == START_BIT) && (line_prev_q == IDLE_LEVEL)) begin
          state_d   = START;
          bit_d     = '0;
          par_err_d = 1'b0;
        end
      end
      START: begin
        if (mid) state_d = (line == START_BIT) ? DATA : IDLE;
      end
      DATA: begin
        if (mid) begin
          shreg_d             = shreg_q >> 1;
          shreg_d[DATA_W-1]   = line;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (mid) begin
          par_err_d = line ^ (^shreg_q);
          state_d   = STOP;
        end
      end
      STOP: begin
        if (mid) begin
          if (line == STOP_BIT) begin
            state_d = IDLE;
            if (par_err_q) begin
              perr_d = 1'b1;
            end else begin
              vout_d = 1'b1;
              dout_d = shreg_q;
            end
          end else begin
            ferr_d  = 1'b1;
            perr_d  = par_err_q;
            state_d = WAIT_LOW;
          end
        end
      end
      WAIT_LOW: begin
        if (line == IDLE_LEVEL) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cyc_q       <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      dout_q      <= '0;
      par_err_q   <= 1'b0;
      line_prev_q <= 1'b0;
      settle_q    <= 2'd0;
      armed_q     <= 1'b0;
      vout_q      <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      dout_q      <= dout_d;
      par_err_q   <= par_err_d;
      line_prev_q <= line_prev_d;
      settle_q    <= settle_d;
      armed_q     <= armed_d;
      vout_q      <= vout_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
    end
  end

  assign dout = dout_q;
  assign vout = vout_q;
  assign perr = perr_q;
  assign ferr = ferr_q;

endmodule

// File: tb/tb_optical_rx.sv
// Directed bench for optical_rx: table of frames plus hand-written corner sequences.
module tb_optical_rx;

  localparam int DW = 8;
  localparam int OS = 4;

  logic          clk;
  logic          rst_n;
  logic          din;
  logic [DW-1:0] dout;
  logic          vout;
  logic          perr;
  logic          ferr;

  optical_rx #(.DATA_W(DW), .OVERSAMPLE(OS), .PARITY_EN(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (din),
    .dout  (dout),
    .vout  (vout),
    .perr  (perr),
    .ferr  (ferr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int cyc_cnt = 0;
  int vcnt = 0, pcnt = 0, fcnt = 0, dbl = 0, vcyc = 0;
  logic [DW-1:0] vals[$];
  logic vout_p = 1'b0, perr_p = 1'b0, ferr_p = 1'b0;

  always @(posedge clk) cyc_cnt++;

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (vout) begin vcnt++; vals.push_back(dout); vcyc = cyc_cnt; end
      if (perr) pcnt++;
      if (ferr) fcnt++;
      if ((vout && vout_p) || (perr && perr_p) || (ferr && ferr_p)) dbl++;
    end
    vout_p = vout;
    perr_p = perr;
    ferr_p = ferr;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bit_out(input logic v);
    din = v;
    repeat (OS) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int nbits);
    din = 1'b0;
    repeat (nbits * OS) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] p, input bit flip, input bit stop1);
    bit_out(1'b1);
    for (int i = 0; i < DW; i++) bit_out(p[i]);
    bit_out((^p) ^ flip);
    bit_out(stop1);
  endtask

  typedef struct {
    logic [7:0] pay;
    bit         flip;
    bit         stop1;
    int         ev;
    int         ep;
    int         ef;
    logic [7:0] ed;
  } vec_t;

  vec_t tbl[8];
  int v0, p0, f0, n0, c0;

  initial begin
    tbl[0] = '{8'h23, 1'b0, 1'b0, 1, 0, 0, 8'h23};
    tbl[1] = '{8'h81, 1'b0, 1'b0, 1, 0, 0, 8'h81};
    tbl[2] = '{8'h23, 1'b1, 1'b0, 0, 1, 0, 8'h81};
    tbl[3] = '{8'h00, 1'b0, 1'b0, 1, 0, 0, 8'h00};
    tbl[4] = '{8'hFF, 1'b0, 1'b0, 1, 0, 0, 8'hFF};
    tbl[5] = '{8'h3C, 1'b0, 1'b1, 0, 0, 1, 8'hFF};
    tbl[6] = '{8'h3C, 1'b1, 1'b1, 0, 1, 1, 8'hFF};
    tbl[7] = '{8'h96, 1'b0, 1'b0, 1, 0, 0, 8'h96};

    din   = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout", dout, 0);
    chk("rst_vout", vout, 0);
    chk("rst_perr", perr, 0);
    chk("rst_ferr", ferr, 0);
    rst_n = 1'b1;
    idle(2);

    // Table of single frames.
    for (int i = 0; i < 8; i++) begin
      v0 = vcnt; p0 = pcnt; f0 = fcnt; n0 = vals.size();
      send_frame(tbl[i].pay, tbl[i].flip, tbl[i].stop1);
      idle(3);
      chk($sformatf("row%0d_vout", i), vcnt - v0, tbl[i].ev);
      chk($sformatf("row%0d_perr", i), pcnt - p0, tbl[i].ep);
      chk($sformatf("row%0d_ferr", i), fcnt - f0, tbl[i].ef);
      chk($sformatf("row%0d_dout", i), dout, tbl[i].ed);
      if (tbl[i].ev == 1)
        chk($sformatf("row%0d_vdat", i), (vals.size() > n0) ? vals[n0] : 32'hDEAD, tbl[i].pay);
    end

    // Latency: start drive after edge c0; stop midpoint is 10*OS+OS/2 = 42 cycles
    // later, plus 2 sync cycles plus 1 register cycle -> vout seen at c0+45.
    c0 = cyc_cnt; v0 = vcnt;
    send_frame(8'hC3, 1'b0, 1'b0);
    idle(3);
    chk("lat_cnt", vcnt - v0, 1);
    chk("lat_cyc", vcyc - c0, 45);

    // One-cycle glitch is rejected, then a normal frame.
    v0 = vcnt; p0 = pcnt; f0 = fcnt;
    din = 1'b1;
    @(posedge clk);
    #1;
    idle(4);
    chk("glitch_v", vcnt - v0, 0);
    chk("glitch_p", pcnt - p0, 0);
    chk("glitch_f", fcnt - f0, 0);
    send_frame(8'hA5, 1'b0, 1'b0);
    idle(3);
    chk("glitch_next_v", vcnt - v0, 1);
    chk("glitch_next_d", dout, 8'hA5);

    // Back-to-back frames without an idle gap.
    v0 = vcnt; n0 = vals.size();
    send_frame(8'h01, 1'b0, 1'b0);
    send_frame(8'hFE, 1'b0, 1'b0);
    idle(3);
    chk("b2b_cnt", vcnt - v0, 2);
    chk("b2b_d0", (vals.size() > n0) ? vals[n0] : 32'hDEAD, 8'h01);
    chk("b2b_d1", (vals.size() > n0 + 1) ? vals[n0 + 1] : 32'hDEAD, 8'hFE);

    // Stuck-high line for 16 bit times: one ferr (all-ones parity also mismatches).
    v0 = vcnt; p0 = pcnt; f0 = fcnt;
    for (int i = 0; i < 16; i++) bit_out(1'b1);
    chk("stuck_f", fcnt - f0, 1);
    chk("stuck_v", vcnt - v0, 0);
    chk("stuck_p", pcnt - p0, 1);
    idle(3);
    chk("stuck_after_f", fcnt - f0, 1);
    chk("stuck_after_v", vcnt - v0, 0);
    chk("stuck_dout", dout, 8'hFE);

    // Reset in the middle of data bit 4, released with the line already high.
    bit_out(1'b1);
    for (int i = 0; i < 4; i++) bit_out(1'b1 & (8'h77 >> i));
    din = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_vout", vout, 0);
    v0 = vcnt; p0 = pcnt; f0 = fcnt;
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) bit_out(1'b1);
    chk("high_rel_v", vcnt - v0, 0);
    chk("high_rel_p", pcnt - p0, 0);
    chk("high_rel_f", fcnt - f0, 0);
    chk("high_rel_d", dout, 0);
    idle(2);
    send_frame(8'h5A, 1'b0, 1'b0);
    idle(3);
    chk("post_rst_v", vcnt - v0, 1);
    chk("post_rst_f", fcnt - f0, 0);
    chk("post_rst_p", pcnt - p0, 0);
    chk("post_rst_d", dout, 8'h5A);

    chk("no_double_pulse", dbl, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
